// File: rtl/sparc_ifu_parchk_pkg.sv
// sparc_ifu_parchk_pkg: shared FSM encoding and default sizing for the IFU parity-check controller
package sparc_ifu_parchk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CHK = 2'd1, ERR_WAIT = 2'd2} state_e;
  localparam int NREQ_DEF  = 4;
  localparam int W_DEF     = 34;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sparc_ifu_rr_arb.sv
// sparc_ifu_rr_arb: NREQ-way round-robin arbiter; the thread after the last winner gets top priority
module sparc_ifu_rr_arb #(
  parameter int NREQ  = 4,
  parameter int TID_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [TID_W-1:0] gnt_idx,
  output logic             gnt_any
);
  logic [TID_W-1:0] ptr_q, ptr_d, idx;
  always_comb begin
    idx     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // scan from farthest to nearest so the thread closest to the pointer wins last
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + TID_W'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
    gnt_any = gnt_any & en;
    gnt     = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d   = gnt_any ? gnt_idx + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
endmodule

// File: rtl/sparc_ifu_parchk_ctl.sv
// sparc_ifu_parchk_ctl: shared 34-bit parity checker with round-robin thread arbitration; IFU_PARCHK_ERRINJ_EN adds one-shot error injection
module sparc_ifu_parchk_ctl
  import sparc_ifu_parchk_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TID_W = $clog2(NREQ)
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_gnt,
  output logic              res_vld,
  output logic [TID_W-1:0]  res_tid,
  output logic              res_err,
  input  logic              err_ack,
  input  logic [NREQ-1:0]   clr_sticky,
  output logic [NREQ-1:0]   err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
`ifdef IFU_PARCHK_ERRINJ_EN
  input  logic              errinj_en,
  input  logic [TID_W-1:0]  errinj_tid,
`endif
  output logic              busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e            state_q, state_d;
  logic [W-1:0]      word_q, word_d;
  logic [TID_W-1:0]  tid_q, tid_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [NREQ-1:0]   sticky_q, sticky_d;
  logic              armed_q, armed_d;
  logic [NREQ-1:0]   arb_gnt;
  logic [TID_W-1:0]  gnt_idx;
  logic              gnt_any, arb_en, par_err, chk_err, inj;
  assign par_err = ^word_q;
  assign chk_err = (state_q == CHK) && par_err;
  // gating with arst_l keeps req_gnt low throughout reset
  assign arb_en  = arst_l && ((state_q == IDLE) || ((state_q == CHK) && !par_err));
  sparc_ifu_rr_arb #(.NREQ(NREQ), .TID_W(TID_W)) u_arb (
    .clk     (rclk),
    .rst_n   (arst_l),
    .req     (req_vld),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  always_ff @(posedge rclk or negedge arst_l)
    if (!arst_l) begin
      state_q   <= IDLE;
      word_q    <= '0;
      tid_q     <= '0;
      err_cnt_q <= '0;
      sticky_q  <= '0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      tid_q     <= tid_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
      armed_q   <= armed_d;
    end
  always_comb begin
    state_d = (state_q == IDLE) ? (gnt_any ? CHK : IDLE) :
              (state_q == CHK)  ? (par_err ? ERR_WAIT : gnt_any ? CHK : IDLE) :
              (err_ack ? IDLE : ERR_WAIT);
  end
  always_comb begin
`ifdef IFU_PARCHK_ERRINJ_EN
    // re-arms only after errinj_en has been low for a cycle
    inj     = gnt_any && errinj_en && armed_q && (gnt_idx == errinj_tid);
    armed_d = !errinj_en ? 1'b1 : inj ? 1'b0 : armed_q;
`else
    inj     = 1'b0;
    armed_d = armed_q;
`endif
    word_d    = gnt_any ? (req_data[gnt_idx*W +: W] ^ {{(W-1){1'b0}}, inj}) : word_q;
    tid_d     = gnt_any ? gnt_idx : tid_q;
    err_cnt_d = (chk_err && err_cnt_q != CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;
    sticky_d  = (sticky_q & ~clr_sticky) | (chk_err ? (NREQ'(1) << tid_q) : '0);
  end
  always_comb begin
    req_gnt    = arb_gnt;
    res_vld    = state_q != IDLE;
    res_tid    = tid_q;
    res_err    = (state_q == ERR_WAIT) || chk_err;
    err_sticky = sticky_q;
    err_cnt    = err_cnt_q;
    busy       = (state_q != IDLE) || (|req_vld);
  end
endmodule

// File: tb/tb_sparc_ifu_parchk_ctl.sv
// tb_sparc_ifu_parchk_ctl: directed stimulus with a result scoreboard checked by an independent monitor
module tb_sparc_ifu_parchk_ctl;
  localparam int NREQ = 4;
  localparam int W    = 34;
  logic              rclk = 1'b0;
  logic              arst_l;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_gnt;
  logic              res_vld;
  logic [1:0]        res_tid;
  logic              res_err;
  logic              err_ack;
  logic [NREQ-1:0]   clr_sticky;
  logic [NREQ-1:0]   err_sticky;
  logic [7:0]        err_cnt;
  logic              busy;
`ifdef IFU_PARCHK_ERRINJ_EN
  logic              errinj_en;
  logic [1:0]        errinj_tid;
`endif
  int checks = 0;
  int failures = 0;
  logic [2:0] sb[$];
  logic [2:0] e;
  logic prev_vld = 1'b0, prev_err = 1'b0;

  sparc_ifu_parchk_ctl dut (
    .rclk       (rclk),
    .arst_l     (arst_l),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_gnt    (req_gnt),
    .res_vld    (res_vld),
    .res_tid    (res_tid),
    .res_err    (res_err),
    .err_ack    (err_ack),
    .clr_sticky (clr_sticky),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
`ifdef IFU_PARCHK_ERRINJ_EN
    .errinj_en  (errinj_en),
    .errinj_tid (errinj_tid),
`endif
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a result is new unless the previous cycle was already showing a held error
  always @(negedge rclk) begin
    if (!arst_l) begin
      prev_vld <= 1'b0;
      prev_err <= 1'b0;
    end else begin
      if (res_vld && !(prev_vld && prev_err)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got result tid=%0d err=%0b expected none", res_tid, res_err);
        end else begin
          e = sb.pop_front();
          chk("res_tid", 64'(res_tid), 64'(e[2:1]));
          chk("res_err", 64'(res_err), 64'(e[0]));
        end
      end
      prev_vld <= res_vld;
      prev_err <= res_err;
    end
  end

  task automatic do_reset();
    @(negedge rclk);
    arst_l = 1'b0;
    #1;
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_res_tid", 64'(res_tid), 64'd0);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    chk("rst_gnt", 64'(req_gnt), 64'd0);
    @(negedge rclk);
    arst_l = 1'b1;
  endtask

  task automatic run_one(input int tid, input logic [W-1:0] w, input logic exp_err, input logic [NREQ-1:0] clr);
    @(negedge rclk);
    req_vld = NREQ'(1) << tid;
    req_data[tid*W +: W] = w;
    #1 chk("gnt_single", 64'(req_gnt), 64'(NREQ'(1) << tid));
    sb.push_back({2'(tid), exp_err});
    @(posedge rclk);
    #1 req_vld = '0;
    clr_sticky = clr;
    @(posedge rclk);
    #1 clr_sticky = '0;
    if (exp_err) begin
      err_ack = 1'b1;
      @(posedge rclk);
      #1 err_ack = 1'b0;
    end
  endtask

  initial begin
    arst_l = 1'b0;
    req_vld = 4'b0100;
    req_data = '0;
    err_ack = 1'b0;
    clr_sticky = '0;
`ifdef IFU_PARCHK_ERRINJ_EN
    errinj_en = 1'b0;
    errinj_tid = 2'd0;
`endif
    req_data[2*W +: W] = 34'h0_0000_0003;
    do_reset();
    #1 chk("t1_gnt", 64'(req_gnt), 64'b0100);
    sb.push_back({2'd2, 1'b0});
    @(posedge rclk);
    #1 req_vld = '0;
    @(negedge rclk);
    #1 chk("t1_cnt", 64'(err_cnt), 64'd0);

    do_reset();
    req_data = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      if (k == 0) req_vld = 4'b1111;
      #1 chk("t2_gnt", 64'(req_gnt), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("t2_res_vld", 64'(res_vld), 64'd1);
      sb.push_back({2'(k % 4), 1'b0});
    end
    @(posedge rclk);
    #1 req_vld = '0;

    @(negedge rclk);
    req_vld = 4'b0010;
    req_data[1*W +: W] = 34'h0_0000_0001;
    #1 chk("t3_gnt", 64'(req_gnt), 64'b0010);
    sb.push_back({2'd1, 1'b1});
    @(posedge rclk);
    #1 req_vld = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      #1 chk("t3_hold_gnt", 64'(req_gnt), 64'd0);
      chk("t3_hold_vld_err", 64'({res_vld, res_err}), 64'b11);
    end
    err_ack = 1'b1;
    @(posedge rclk);
    #1 err_ack = 1'b0;
    @(negedge rclk);
    #1 chk("t3_gnt_after_ack", 64'(req_gnt), 64'b0001);
    sb.push_back({2'd0, 1'b0});
    @(posedge rclk);
    #1 req_vld = '0;
    chk("t3_cnt", 64'(err_cnt), 64'd1);
    chk("t3_sticky", 64'(err_sticky), 64'b0010);

    for (int n = 0; n < 254; n++) run_one(1, 34'h0_0000_0001, 1'b1, 4'b0000);
    chk("t4_cnt_max", 64'(err_cnt), 64'd255);
    run_one(0, 34'h3_0000_0000, 1'b0, 4'b0010);
    chk("t4_sticky_cleared", 64'(err_sticky), 64'd0);
    run_one(1, 34'h2_0000_0000, 1'b1, 4'b0010);
    chk("t4_cnt_sat", 64'(err_cnt), 64'd255);
    chk("t4_set_wins", 64'(err_sticky), 64'b0010);

    @(negedge rclk);
    req_vld = 4'b0010;
    req_data[1*W +: W] = 34'h0_0000_0001;
    #1 chk("t5_gnt", 64'(req_gnt), 64'b0010);
    sb.push_back({2'd1, 1'b1});
    @(posedge rclk);
    #1 req_vld = 4'b1111;
    req_data = '0;
    @(negedge rclk);
    #1 chk("t5_chk_err_no_gnt", 64'(req_gnt), 64'd0);
    do_reset();
    #1 chk("t5_gnt_after_rst", 64'(req_gnt), 64'b0001);
    sb.push_back({2'd0, 1'b0});
    @(posedge rclk);
    #1 req_vld = '0;

`ifdef IFU_PARCHK_ERRINJ_EN
    errinj_tid = 2'd3;
    errinj_en = 1'b1;
    run_one(3, 34'h0, 1'b1, 4'b0000);
    run_one(3, 34'h0, 1'b0, 4'b0000);
    errinj_en = 1'b0;
    chk("t6_sticky", 64'(err_sticky), 64'b1000);
`endif

    repeat (3) @(negedge rclk);
    #1 chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
